// File: rtl/car_sim_pkg.sv
// -----------------------------------------------------------------------------
// car_sim_pkg
// Shared definitions for the car simulation pipeline: the car FSM state
// encoding and the default step/limit constants, also used by the display and
// LED stages so that every stage agrees on units and state codes.
// -----------------------------------------------------------------------------
package car_sim_pkg;

    // Encoding is visible on the state output and decoded by the LED stage.
    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ACCEL  = 3'd2,
        ST_CRUISE = 3'd3,
        ST_BRAKE  = 3'd4
    } car_state_t;

    localparam int CAR_SPD_W     = 8;
    localparam int CAR_POS_W     = 16;
    localparam int CAR_MAX_SPEED = 100;
    localparam int CAR_ACC_STEP  = 2;
    localparam int CAR_BRK_STEP  = 5;
    localparam int CAR_DRAG_STEP = 1;
    localparam int CAR_TRACK_LEN = 1000;

endpackage

// File: rtl/tick_edge_det.sv
// -----------------------------------------------------------------------------
// tick_edge_det
// Rising-edge detector for divider outputs that already live in the clk domain
// (no synchroniser). The history register resets to 0, so an input that is
// already high when reset is released yields one rise in the first cycle.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   sig_i   in  level signal from the divider
//   rise_o  out one-cycle pulse, sig_i & ~previous sig_i
// -----------------------------------------------------------------------------
module tick_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic tick_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~tick_q;

endmodule

// File: rtl/car_motion_ctrl.sv
// -----------------------------------------------------------------------------
// car_motion_ctrl
// Car model advanced once per rising edge of the 50 ms divided tick. Each
// update moves the track position by the pre-update speed (wrapping at
// TRACK_LEN), then applies brake / accel / coast to a saturating speed and
// records the applied command as the FSM state.
// Optional feature: define CAR_ODOMETER_EN to add a saturating 32-bit
// odometer output accumulating the pre-update speed on every update.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   tick_in     50 ms divided clock (level, same clk domain)
//   engine_on   level: engine running
//   accel       level: accelerator pressed (ignored while engine is off)
//   brake       level: brake pressed (wins over accel)
//   speed       current speed, units per update
//   position    track position 0..TRACK_LEN-1
//   state       car_state_t code (OFF/IDLE/ACCEL/CRUISE/BRAKE)
//   moving      speed != 0
//   upd_pulse   high for the one cycle after each update
//   odometer    total distance (CAR_ODOMETER_EN only)
// -----------------------------------------------------------------------------
module car_motion_ctrl
    import car_sim_pkg::*;
#(
    parameter int SPD_W     = CAR_SPD_W,
    parameter int POS_W     = CAR_POS_W,
    parameter int MAX_SPEED = CAR_MAX_SPEED,
    parameter int ACC_STEP  = CAR_ACC_STEP,
    parameter int BRK_STEP  = CAR_BRK_STEP,
    parameter int DRAG_STEP = CAR_DRAG_STEP,
    parameter int TRACK_LEN = CAR_TRACK_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             engine_on,
    input  logic             accel,
    input  logic             brake,
    output logic [SPD_W-1:0] speed,
    output logic [POS_W-1:0] position,
    output logic [2:0]       state,
    output logic             moving,
`ifdef CAR_ODOMETER_EN
    output logic [31:0]      odometer,
`endif
    output logic             upd_pulse
);

    localparam logic [SPD_W:0]   MAX_W   = (SPD_W+1)'(MAX_SPEED);
    localparam logic [SPD_W-1:0] MAX_S   = SPD_W'(MAX_SPEED);
    localparam logic [SPD_W:0]   ACC_W   = (SPD_W+1)'(ACC_STEP);
    localparam logic [SPD_W-1:0] BRK_S   = SPD_W'(BRK_STEP);
    localparam logic [SPD_W-1:0] DRAG_S  = SPD_W'(DRAG_STEP);
    localparam logic [POS_W:0]   TRACK_W = (POS_W+1)'(TRACK_LEN);

    logic tick_rise;

    tick_edge_det u_tick_edge_det (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (tick_in),
        .rise_o (tick_rise)
    );

    logic [SPD_W-1:0] speed_q, speed_d;
    logic [POS_W-1:0] pos_q, pos_d;
    car_state_t       state_q, state_d;
    logic             upd_q;

    logic [POS_W:0]   spd_ext;
    logic [POS_W:0]   pos_sum;
    logic [SPD_W:0]   acc_sum;

    assign spd_ext = {{(POS_W+1-SPD_W){1'b0}}, speed_q};
    assign pos_sum = {1'b0, pos_q} + spd_ext;
    assign acc_sum = {1'b0, speed_q} + ACC_W;

    always_comb begin
        // A single subtraction is enough because MAX_SPEED < TRACK_LEN.
        pos_d   = (pos_sum >= TRACK_W) ? POS_W'(pos_sum - TRACK_W) : POS_W'(pos_sum);
        speed_d = speed_q;
        state_d = state_q;
        if (brake) begin
            speed_d = (speed_q > BRK_S) ? (speed_q - BRK_S) : '0;
            state_d = ST_BRAKE;
        end else if (accel && engine_on) begin
            speed_d = (acc_sum > MAX_W) ? MAX_S : acc_sum[SPD_W-1:0];
            state_d = ST_ACCEL;
        end else if (speed_q != '0) begin
            speed_d = (speed_q > DRAG_S) ? (speed_q - DRAG_S) : '0;
            state_d = ST_CRUISE;
        end else begin
            state_d = engine_on ? ST_IDLE : ST_OFF;
        end
    end

`ifdef CAR_ODOMETER_EN
    logic [31:0] odo_q, odo_d;
    logic [32:0] odo_sum;

    assign odo_sum = {1'b0, odo_q} + 33'(speed_q);
    // Saturate instead of wrapping on carry out.
    assign odo_d   = odo_sum[32] ? 32'hFFFF_FFFF : odo_sum[31:0];
    assign odometer = odo_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_q <= '0;
            pos_q   <= '0;
            state_q <= ST_OFF;
            upd_q   <= 1'b0;
`ifdef CAR_ODOMETER_EN
            odo_q   <= '0;
`endif
        end else begin
            upd_q <= tick_rise;
            if (tick_rise) begin
                speed_q <= speed_d;
                pos_q   <= pos_d;
                state_q <= state_d;
`ifdef CAR_ODOMETER_EN
                odo_q   <= odo_d;
`endif
            end
        end
    end

    assign speed     = speed_q;
    assign position  = pos_q;
    assign state     = state_q;
    assign moving    = (speed_q != '0);
    assign upd_pulse = upd_q;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_car_motion_ctrl
// Directed bench for car_motion_ctrl. Expected speeds/states are written out
// per step; the track position is tracked with a plain modulo accumulator of
// the previously expected speed.
// -----------------------------------------------------------------------------
module tb_car_motion_ctrl;
    import car_sim_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       tick_in;
    logic       engine_on;
    logic       accel;
    logic       brake;
    logic [7:0]  speed;
    logic [15:0] position;
    logic [2:0]  state;
    logic        moving;
    logic        upd_pulse;
`ifdef CAR_ODOMETER_EN
    logic [31:0] odometer;
`endif

    always #5 clk = ~clk;

    car_motion_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .engine_on (engine_on),
        .accel     (accel),
        .brake     (brake),
        .speed     (speed),
        .position  (position),
        .state     (state),
        .moving    (moving),
`ifdef CAR_ODOMETER_EN
        .odometer  (odometer),
`endif
        .upd_pulse (upd_pulse)
    );

    // ---------------- scoreboard ----------------
    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_pos = 0;
    int exp_spd = 0;
    int exp_odo = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One tick pulse; checks the values visible in the cycle after the update.
    task automatic do_tick(input int want_spd, input car_state_t want_st, input string tag);
        exp_odo = exp_odo + exp_spd;
        exp_pos = (exp_pos + exp_spd) % 1000;
        @(negedge clk);
        tick_in = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_spd"}, 32'(speed), want_spd);
        check_eq({tag, "_st"},  32'(state), 32'(want_st));
        check_eq({tag, "_pos"}, 32'(position), exp_pos);
        check_eq({tag, "_upd"}, 32'(upd_pulse), 32'd1);
        exp_spd = want_spd;
        @(negedge clk);
        tick_in = 1'b0;
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (upd_pulse) n++;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst       = 1'b1;
        tick_in   = 1'b0;
        engine_on = 1'b0;
        accel     = 1'b0;
        brake     = 1'b0;

        // 1. Reset held with tick toggling: nothing moves.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tick_in = ~tick_in;
        end
        check_eq("rst_spd", 32'(speed), 32'd0);
        check_eq("rst_pos", 32'(position), 32'd0);
        check_eq("rst_st",  32'(state), 32'(ST_OFF));
        check_eq("rst_upd", 32'(upd_pulse), 32'd0);
        check_eq("rst_mov", 32'(moving), 32'd0);
        tick_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_tick(0, ST_OFF, "t1_off");
        @(posedge clk);
        #1;
        check_eq("t1_upd_drop", 32'(upd_pulse), 32'd0);

        // 2. Accelerate 52 ticks: 2,4,..,100 then saturate.
        engine_on = 1'b1;
        accel     = 1'b1;
        for (int k = 1; k <= 52; k++) begin
            do_tick((2 * k > 100) ? 100 : 2 * k, ST_ACCEL, "t2_acc");
        end
        check_eq("t2_pos_final", 32'(position), 32'd650);
        check_eq("t2_moving", 32'(moving), 32'd1);

        // 3. Brake 100 -> 10, coast to 7, brake 7 -> 2 -> 0, then IDLE.
        accel = 1'b0;
        brake = 1'b1;
        for (int k = 1; k <= 18; k++) do_tick(100 - 5 * k, ST_BRAKE, "t3_brk");
        brake = 1'b0;
        for (int k = 1; k <= 3; k++) do_tick(10 - k, ST_CRUISE, "t3_cst");
        brake = 1'b1;
        do_tick(2, ST_BRAKE, "t3_brk7");
        do_tick(0, ST_BRAKE, "t3_brk2");
        check_eq("t3_moving0", 32'(moving), 32'd0);
        brake = 1'b0;
        do_tick(0, ST_IDLE, "t3_idle");

        // 5. Accel+brake at 50 -> 45 BRAKE; engine off with accel at 3 -> coast.
        accel = 1'b1;
        for (int k = 1; k <= 25; k++) do_tick(2 * k, ST_ACCEL, "t5_acc");
        brake = 1'b1;
        do_tick(45, ST_BRAKE, "t5_both");
        accel = 1'b0;
        for (int k = 1; k <= 8; k++) do_tick(45 - 5 * k, ST_BRAKE, "t5_brk");
        brake = 1'b0;
        do_tick(4, ST_CRUISE, "t5_cst4");
        do_tick(3, ST_CRUISE, "t5_cst3");
        engine_on = 1'b0;
        accel     = 1'b1;
        do_tick(2, ST_CRUISE, "t5_off2");
        do_tick(1, ST_CRUISE, "t5_off1");
        do_tick(0, ST_CRUISE, "t5_off0");
        do_tick(0, ST_OFF, "t5_offst");

        // 6a. tick_in held high for 10 cycles: exactly one update.
        engine_on = 1'b1;
        @(negedge clk);
        tick_in = 1'b1;
        count_pulses(10, n);
        check_eq("t6_hold_pulses", 32'(n), 32'd1);
        check_eq("t6_hold_spd", 32'(speed), 32'd2);
        check_eq("t6_hold_st", 32'(state), 32'(ST_ACCEL));
        check_eq("t6_hold_pos", 32'(position), exp_pos);
        tick_in = 1'b0;

        // 6b. Async reset mid-run with tick_in held high through release.
        @(negedge clk);
        tick_in = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_spd", 32'(speed), 32'd0);
        check_eq("t6_rst_pos", 32'(position), 32'd0);
        check_eq("t6_rst_st",  32'(state), 32'(ST_OFF));
        check_eq("t6_rst_upd", 32'(upd_pulse), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_pulses(10, n);
        check_eq("t6_rel_pulses", 32'(n), 32'd1);
        check_eq("t6_rel_spd", 32'(speed), 32'd2);
        check_eq("t6_rel_pos", 32'(position), 32'd0);
        tick_in = 1'b0;

        // 4. From a clean reset: offset 50, reach 100, land exactly on TRACK_LEN.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_pos = 0;
        exp_spd = 0;
        exp_odo = 0;
        for (int k = 0; k < 25; k++) begin
            accel = 1'b1;
            brake = 1'b0;
            do_tick(2, ST_ACCEL, "t4_pa");
            accel = 1'b0;
            brake = 1'b1;
            do_tick(0, ST_BRAKE, "t4_pb");
        end
        brake = 1'b0;
        accel = 1'b1;
        for (int k = 1; k <= 50; k++) do_tick(2 * k, ST_ACCEL, "t4_acc");
        check_eq("t4_pos500", 32'(position), 32'd500);
        for (int k = 1; k <= 5; k++) do_tick(100, ST_ACCEL, "t4_run");
        check_eq("t4_wrap_exact", 32'(position), 32'd0);
`ifdef CAR_ODOMETER_EN
        check_eq("t4_odo", odometer, 32'd3000);
        check_eq("t4_odo_model", odometer, exp_odo);
`endif

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
